reg_write_arbiter: RTL and testbench

Round-robin arbiter that lets several requesters share the write port of a bank of `register` instances. It holds no data of its own. It picks one pending write per cycle and drives the one-hot `wenable` lines and the shared `in` bus of the bank. It sits between the datapath units that update machine state (CPU core, I/O port logic, interrupt logic) and the register bank they share.

---
 rtl/reg_write_arbiter.sv | 106 ++++++++++
 tb/tb_reg_write_arbiter.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reg_write_arbiter.sv
// rtl/reg_write_arbiter.sv - round-robin arbiter for the shared write port of a register bank
// Picks one pending write per cycle and drives the bank's one-hot write enables and data bus.
module reg_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int WIDTH    = 8,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*WIDTH-1:0]  req_data,
  input  logic                      freeze,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REGS-1:0]       reg_we,
  output logic [WIDTH-1:0]          reg_in,
  output logic                      pending
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W:0]  REQ_LIMIT = (PTR_W+1)'(NUM_REQ);
  localparam logic [ADDR_W:0] REG_LIMIT = (ADDR_W+1)'(NUM_REGS);

  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    win;
  logic [PTR_W-1:0]    ptr_next;
  logic                found;
  logic [NUM_REQ-1:0]  elig;
  logic [NUM_REQ-1:0]  gnt_next;
  logic [NUM_REGS-1:0] we_next;
  logic [ADDR_W-1:0]   win_addr;
  logic [WIDTH-1:0]    win_data;
  logic [PTR_W:0]      cand_sum;
  logic [PTR_W-1:0]    cand;

  // The requester granted this cycle is masked so a held request cannot win twice in a row.
  assign elig    = req & ~gnt;
  assign pending = |elig;

  // Scan from the farthest offset down so the candidate closest to ptr is the one left standing.
  always_comb begin
    win      = ptr;
    found    = 1'b0;
    cand_sum = '0;
    cand     = '0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      cand_sum = {1'b0, ptr} + (PTR_W+1)'(off);
      if (cand_sum >= REQ_LIMIT) begin
        cand_sum = cand_sum - REQ_LIMIT;
      end
      cand = cand_sum[PTR_W-1:0];
      if (elig[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

  always_comb begin
    win_addr = '0;
    win_data = '0;
    gnt_next = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (PTR_W'(i) == win) begin
        win_addr    = req_addr[i*ADDR_W +: ADDR_W];
        win_data    = req_data[i*WIDTH +: WIDTH];
        gnt_next[i] = 1'b1;
      end
    end
  end

  // Addresses beyond the bank are still granted and consumed, but enable nothing.
  always_comb begin
    we_next = '0;
    if ({1'b0, win_addr} < REG_LIMIT) begin
      we_next[win_addr] = 1'b1;
    end
  end

  always_comb begin
    if (win == PTR_W'(NUM_REQ - 1)) begin
      ptr_next = '0;
    end else begin
      ptr_next = win + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt    <= '0;
      reg_we <= '0;
      reg_in <= '0;
      ptr    <= '0;
    end else if (!freeze && found) begin
      gnt    <= gnt_next;
      reg_we <= we_next;
      reg_in <= win_data;
      ptr    <= ptr_next;
    end else begin
      gnt    <= '0;
      reg_we <= '0;
    end
  end

endmodule

// File: tb/tb_reg_write_arbiter.sv
// tb/tb_reg_write_arbiter.sv - self-checking bench for reg_write_arbiter
// Scenario tasks plus a randomized run compared against a behavioural arbitration model.
module tb_reg_write_arbiter;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int R  = 8;
  localparam int AW = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N*AW-1:0] req_addr;
  logic [N*W-1:0]  req_data;
  logic            freeze;
  logic [N-1:0]    gnt;
  logic [R-1:0]    reg_we;
  logic [W-1:0]    reg_in;
  logic            pending;
  logic [N-1:0]    gnt6;
  logic [5:0]      reg_we6;
  logic [W-1:0]    reg_in6;
  logic            pending6;

  logic [AW-1:0]   a [N];
  logic [W-1:0]    d [N];
  logic [W-1:0]    bank [R];

  int n_checks = 0;
  int n_fail   = 0;

  int           m_ptr;
  logic [N-1:0] m_gnt;
  logic [R-1:0] m_we;
  logic [W-1:0] m_in;

  always #5 clk = ~clk;

  always_comb begin
    req_addr = '0;
    req_data = '0;
    for (int i = 0; i < N; i++) begin
      req_addr[i*AW +: AW] = a[i];
      req_data[i*W +: W]   = d[i];
    end
  end

  always @(posedge clk) begin
    for (int j = 0; j < R; j++) begin
      if (reg_we[j]) bank[j] <= reg_in;
    end
  end

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .NUM_REGS(R)) u_dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .freeze(freeze), .gnt(gnt), .reg_we(reg_we), .reg_in(reg_in), .pending(pending)
  );

  reg_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .NUM_REGS(6)) u_dut6 (
    .clk(clk), .rst_n(rst_n), .req(req), .req_addr(req_addr), .req_data(req_data),
    .freeze(freeze), .gnt(gnt6), .reg_we(reg_we6), .reg_in(reg_in6), .pending(pending6)
  );

  task automatic model_reset();
    m_ptr = 0;
    m_gnt = '0;
    m_we  = '0;
    m_in  = '0;
  endtask

  // Round-robin rule: first requester at or after ptr (wrapping) that asks and was not just granted.
  task automatic model_edge();
    logic [N-1:0] el;
    int k;
    el = req & ~m_gnt;
    k  = -1;
    if (!freeze) begin
      for (int i = 0; i < N; i++) begin
        if (k < 0 && el[2'((m_ptr + i) % N)]) k = (m_ptr + i) % N;
      end
    end
    if (k >= 0) begin
      m_gnt = N'(1) << k;
      m_in  = d[k];
      m_we  = (int'(a[k]) < R) ? (R'(1) << a[k]) : '0;
      m_ptr = (k + 1) % N;
    end else begin
      m_gnt = '0;
      m_we  = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n  = 1'b0;
    req    = '0;
    freeze = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (reg_we !== 8'h00) begin n_fail++; $display("FAIL reset_we got=%h exp=00", reg_we); end
    n_checks++; if (reg_in !== 8'h00) begin n_fail++; $display("FAIL reset_in got=%h exp=00", reg_in); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL reset_pending got=%b exp=0", pending); end
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin d[i] = W'(8'h10 + i); a[i] = AW'(i); end
    req = 4'b1111;
    step();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL reset_first_gnt got=%b exp=0001", gnt); end
    n_checks++; if (reg_in !== 8'h10) begin n_fail++; $display("FAIL reset_first_in got=%h exp=10", reg_in); end
    step();
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL async_reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (reg_we !== 8'h00) begin n_fail++; $display("FAIL async_reset_we got=%h exp=00", reg_we); end
    n_checks++; if (reg_in !== 8'h00) begin n_fail++; $display("FAIL async_reset_in got=%h exp=00", reg_in); end
    model_reset();
    req = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_single_write();
    req  = 4'b0100;
    a[2] = 3'd5;
    d[2] = 8'hA5;
    step();
    n_checks++; if (gnt !== 4'b0100) begin n_fail++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
    n_checks++; if (reg_we !== 8'b0010_0000) begin n_fail++; $display("FAIL single_we got=%b exp=00100000", reg_we); end
    n_checks++; if (reg_in !== 8'hA5) begin n_fail++; $display("FAIL single_in got=%h exp=a5", reg_in); end
    n_checks++; if (pending !== 1'b0) begin n_fail++; $display("FAIL single_pending got=%b exp=0", pending); end
    req = '0;
    step();
    n_checks++; if (bank[5] !== 8'hA5) begin n_fail++; $display("FAIL single_bank got=%h exp=a5", bank[5]); end
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL single_idle got=%b exp=0000", gnt); end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] exp_gnt;
    logic [R-1:0] exp_we;
    do_reset();
    for (int i = 0; i < N; i++) begin d[i] = W'($urandom); a[i] = AW'($urandom); end
    req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      step();
      exp_gnt = N'(1) << (c % N);
      exp_we  = R'(1) << a[c % N];
      n_checks++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL rr_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
      n_checks++; if (reg_in !== d[c % N]) begin n_fail++; $display("FAIL rr_in cyc=%0d got=%h exp=%h", c, reg_in, d[c % N]); end
      n_checks++; if (reg_we !== exp_we) begin n_fail++; $display("FAIL rr_we cyc=%0d got=%b exp=%b", c, reg_we, exp_we); end
    end
    req = '0;
    step();
  endtask

  task automatic test_hog();
    logic [N-1:0] exp_gnt;
    req = 4'b0010;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_gnt = (c % 2 == 0) ? 4'b0010 : 4'b0000;
      n_checks++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL hog_gnt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
    end
    req = 4'b0011;
    for (int c = 0; c < 6; c++) begin
      step();
      exp_gnt = (c % 2 == 0) ? 4'b0001 : 4'b0010;
      n_checks++; if (gnt !== exp_gnt) begin n_fail++; $display("FAIL hog_alt cyc=%0d got=%b exp=%b", c, gnt, exp_gnt); end
    end
    req = '0;
    step();
  endtask

  task automatic test_freeze();
    logic [W-1:0] held;
    step();
    held   = m_in;
    freeze = 1'b1;
    req    = 4'b0001;
    a[0]   = 3'd3;
    d[0]   = W'($urandom);
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL frz_gnt cyc=%0d got=%b exp=0000", c, gnt); end
      n_checks++; if (pending !== 1'b1) begin n_fail++; $display("FAIL frz_pending cyc=%0d got=%b exp=1", c, pending); end
      n_checks++; if (reg_in !== held) begin n_fail++; $display("FAIL frz_in_held cyc=%0d got=%h exp=%h", c, reg_in, held); end
    end
    freeze = 1'b0;
    step();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL frz_release_gnt got=%b exp=0001", gnt); end
    n_checks++; if (reg_we !== 8'h08) begin n_fail++; $display("FAIL frz_release_we got=%h exp=08", reg_we); end
    n_checks++; if (reg_in !== d[0]) begin n_fail++; $display("FAIL frz_release_in got=%h exp=%h", reg_in, d[0]); end
    req = '0;
    step();
  endtask

  task automatic test_range();
    do_reset();
    req  = 4'b0001;
    a[0] = 3'd7;
    d[0] = 8'h3C;
    step();
    n_checks++; if (gnt6 !== 4'b0001) begin n_fail++; $display("FAIL range_gnt got=%b exp=0001", gnt6); end
    n_checks++; if (reg_we6 !== 6'b000000) begin n_fail++; $display("FAIL range_we got=%b exp=000000", reg_we6); end
    n_checks++; if (reg_in6 !== 8'h3C) begin n_fail++; $display("FAIL range_in got=%h exp=3c", reg_in6); end
    n_checks++; if (reg_we !== 8'h80) begin n_fail++; $display("FAIL range_full_we got=%h exp=80", reg_we); end
    a[0] = 3'd5;
    d[0] = 8'h5A;
    step();
    n_checks++; if (gnt6 !== 4'b0000) begin n_fail++; $display("FAIL range_mask got=%b exp=0000", gnt6); end
    step();
    n_checks++; if (reg_we6 !== 6'b100000) begin n_fail++; $display("FAIL range_top_we got=%b exp=100000", reg_we6); end
    n_checks++; if (reg_in6 !== 8'h5A) begin n_fail++; $display("FAIL range_top_in got=%h exp=5a", reg_in6); end
    req = '0;
    step();
  endtask

  task automatic test_reset_mid();
    bit seen;
    do_reset();
    req  = 4'b1111;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      step();
      if (gnt === 4'b0100) seen = 1'b1;
    end
    n_checks++; if (!seen) begin n_fail++; $display("FAIL mid_reach_0100 got=%b exp=0100", gnt); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (gnt !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_gnt got=%b exp=0000", gnt); end
    n_checks++; if (reg_we !== 8'h00) begin n_fail++; $display("FAIL mid_reset_we got=%h exp=00", reg_we); end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step();
    n_checks++; if (gnt !== 4'b0001) begin n_fail++; $display("FAIL mid_first_gnt got=%b exp=0001", gnt); end
    req = '0;
    step();
  endtask

  task automatic test_random();
    int wait_cnt [N];
    int max_wait;
    logic [N-1:0] req_before;
    logic exp_pending;
    do_reset();
    max_wait = 0;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      freeze = (cyc < 200) ? ($urandom_range(0, 4) == 0) : 1'b0;
      for (int i = 0; i < N; i++) begin
        if (req[i]) begin
          if (gnt[i]) begin
            if ($urandom_range(0, 1) == 1) begin
              a[i] = AW'($urandom);
              d[i] = W'($urandom);
            end else begin
              req[i] = 1'b0;
            end
          end
        end else if ($urandom_range(0, 4) < 2) begin
          req[i] = 1'b1;
          a[i]   = AW'($urandom);
          d[i]   = W'($urandom);
        end
      end
      req_before = req;
      step();
      exp_pending = |(req & ~m_gnt);
      n_checks++; if (gnt !== m_gnt) begin n_fail++; $display("FAIL rnd_gnt cyc=%0d got=%b exp=%b", cyc, gnt, m_gnt); end
      n_checks++; if (reg_we !== m_we) begin n_fail++; $display("FAIL rnd_we cyc=%0d got=%b exp=%b", cyc, reg_we, m_we); end
      n_checks++; if (reg_in !== m_in) begin n_fail++; $display("FAIL rnd_in cyc=%0d got=%h exp=%h", cyc, reg_in, m_in); end
      n_checks++; if (pending !== exp_pending) begin n_fail++; $display("FAIL rnd_pending cyc=%0d got=%b exp=%b", cyc, pending, exp_pending); end
      if (cyc >= 200) begin
        for (int i = 0; i < N; i++) begin
          if (req_before[i] && !gnt[i]) wait_cnt[i]++;
          else wait_cnt[i] = 0;
          if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
      end
    end
    n_checks++; if (max_wait > N - 1) begin n_fail++; $display("FAIL rnd_max_wait got=%0d exp<=%0d", max_wait, N - 1); end
    req    = '0;
    freeze = 1'b0;
    step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n  = 1'b0;
    req    = '0;
    freeze = 1'b0;
    for (int i = 0; i < N; i++) begin a[i] = '0; d[i] = '0; end
    for (int j = 0; j < R; j++) bank[j] = '0;
    model_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_hog();
    test_freeze();
    test_range();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
